// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision normalize/round/pack back end:
// field widths, the mantissa and exponent widths used between stages, the
// special encodings and the control state encoding.
package fp_pkg;

  localparam int FRACTION = 23;
  localparam int EXPONENT = 8;
  localparam int BIAS     = 127;

  // Mantissa layout, MSB down: carry, hidden, fraction, G, R, S.
  localparam int MW   = FRACTION + 5;
  // Signed biased exponent width at the interface.
  localparam int EW   = EXPONENT + 2;
  // Internal exponent width; two extra bits so increments never wrap.
  localparam int XW   = EW + 2;
  // Significand width seen by the rounder (hidden bit plus fraction).
  localparam int SIGW = FRACTION + 1;

  localparam int          EXP_MAX = 2 * BIAS + 1;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL,
    NORM,
    ROUND,
    DONE
  } fsmState;

  // Assemble an IEEE-754 single-precision word from its three fields.
  function automatic logic [31:0] packWord(
    input logic                sign,
    input logic [EXPONENT-1:0] expField,
    input logic [FRACTION-1:0] fracField
  );
    return {sign, expField, fracField};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a significand with its guard/round/sticky bits.
// Purely combinational; the caller handles the carry-out renormalization.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [SIGW-1:0] sigIn,
  input  logic [2:0]      grs,
  output logic [SIGW-1:0] sigOut,
  output logic            carryOut,
  output logic            inexact
);

  logic            roundUp;
  logic [SIGW:0]   sum;

  // Increment when above half, or exactly half with an odd LSB.
  always_comb begin
    roundUp  = grs[2] & (grs[1] | grs[0] | sigIn[0]);
    sum      = {1'b0, sigIn} + {{SIGW{1'b0}}, roundUp};
    sigOut   = sum[SIGW-1:0];
    carryOut = sum[SIGW];
    inexact  = |grs;
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalizes an unpacked FP result one shift per cycle, rounds it to nearest
// even and packs it into an IEEE-754 single-precision word, with valid/ready
// handshakes on both sides and a single operation in flight.
// Build option: define FP_DENORM_EN to produce subnormal results; without it
// tiny nonzero results are flushed to signed zero with underflow and inexact.
module fp_normalize_pack
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW-1:0] in_mant,
  input  logic          in_nan,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic          out_overflow,
  output logic          out_underflow,
  output logic          out_inexact
);

  localparam logic signed [XW-1:0] EXP_ONE    = XW'(1);
  localparam logic signed [XW-1:0] TINY_LIMIT = XW'(-MW);
  localparam logic signed [XW-1:0] EXP_OVF    = XW'(EXP_MAX);

  fsmState                state;
  logic                   signR;
  logic signed [XW-1:0]   expR;
  logic [MW-1:0]          mantR;
  logic                   isNanR;
  logic                   isInfR;
  logic                   tinyR;

  logic signed [XW-1:0]   expInExt;
  logic                   tinyIn;

  logic [MW-1:0]          normMant;
  logic signed [XW-1:0]   normExp;
  logic                   normGoRound;

  logic [SIGW-1:0]        rndSig;
  logic                   rndCarry;
  logic                   rndInexact;

  logic [SIGW-1:0]        sigFinal;
  logic signed [XW-1:0]   expFinal;
  logic [31:0]            roundWord;
  logic                   roundOv;
  logic                   roundUf;
  logic                   roundInx;
  logic [31:0]            specialWord;

  assign in_ready = (state == IDLE);

  // Sign-extend the incoming exponent and spot operands far below the
  // smallest subnormal, which collapse straight to a sticky-only mantissa.
  always_comb begin
    expInExt = {{(XW-EW){in_exp[EW-1]}}, in_exp};
    tinyIn   = (expInExt <= TINY_LIMIT);
  end

  // One normalization step: decide the next mantissa/exponent or hand off.
  always_comb begin
    normMant    = mantR;
    normExp     = expR;
    normGoRound = 1'b0;
    if (tinyR) begin
      normMant = {{(MW-1){1'b0}}, |mantR};
      normExp  = EXP_ONE;
    end else if (mantR[MW-1] || (expR < EXP_ONE)) begin
      normMant = {1'b0, mantR[MW-1:2], mantR[1] | mantR[0]};
      normExp  = expR + EXP_ONE;
    end else if (mantR == '0) begin
      normGoRound = 1'b1;
    end else if (!mantR[MW-2] && (expR > EXP_ONE)) begin
      normMant = {mantR[MW-2:0], 1'b0};
      normExp  = expR - EXP_ONE;
    end else begin
      normGoRound = 1'b1;
    end
  end

  fp_round_rne uRound (
    .sigIn    (mantR[MW-2:3]),
    .grs      (mantR[2:0]),
    .sigOut   (rndSig),
    .carryOut (rndCarry),
    .inexact  (rndInexact)
  );

  // Finish rounding: renormalize on carry, then classify and pack.
  always_comb begin
    sigFinal  = rndCarry ? {1'b1, rndSig[SIGW-1:1]} : rndSig;
    expFinal  = rndCarry ? (expR + EXP_ONE) : expR;
    roundWord = packWord(signR, '0, '0);
    roundOv   = 1'b0;
    roundUf   = 1'b0;
    roundInx  = 1'b0;
    if (mantR == '0) begin
      roundWord = packWord(signR, '0, '0);
    end else if (expFinal >= EXP_OVF) begin
      roundWord = packWord(signR, '1, '0);
      roundOv   = 1'b1;
      roundInx  = 1'b1;
    end else if (sigFinal[SIGW-1]) begin
      roundWord = packWord(signR, expFinal[EXPONENT-1:0], sigFinal[FRACTION-1:0]);
      roundInx  = rndInexact;
    end else begin
`ifdef FP_DENORM_EN
      roundWord = packWord(signR, '0, sigFinal[FRACTION-1:0]);
      roundInx  = rndInexact;
      roundUf   = (|sigFinal[FRACTION-1:0]) & rndInexact;
`else
      roundWord = packWord(signR, '0, '0);
      roundInx  = 1'b1;
      roundUf   = 1'b1;
`endif
    end
  end

  // NaN wins over infinity; infinity keeps the operand sign.
  always_comb begin
    specialWord = isNanR ? QNAN : packWord(signR, '1, '0);
  end

  // Control FSM with registered outputs and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      signR         <= 1'b0;
      expR          <= '0;
      mantR         <= '0;
      isNanR        <= 1'b0;
      isInfR        <= 1'b0;
      tinyR         <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            signR  <= in_sign;
            expR   <= expInExt;
            mantR  <= in_mant;
            isNanR <= in_nan;
            isInfR <= in_inf;
            tinyR  <= tinyIn & ~(in_nan | in_inf);
            state  <= (in_nan | in_inf) ? SPECIAL : NORM;
          end
        end
        SPECIAL: begin
          out_result    <= specialWord;
          out_overflow  <= 1'b0;
          out_underflow <= 1'b0;
          out_inexact   <= 1'b0;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
        NORM: begin
          tinyR <= 1'b0;
          if (normGoRound) begin
            state <= ROUND;
          end else begin
            mantR <= normMant;
            expR  <= normExp;
          end
        end
        ROUND: begin
          out_result    <= roundWord;
          out_overflow  <= roundOv;
          out_underflow <= roundUf;
          out_inexact   <= roundInx;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // isInfR only steers the SPECIAL path decision taken at accept time; keep
  // it observable so the operand record stays complete.
  logic unusedInf;
  assign unusedInf = isInfR;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: directed plan cases plus random
// operands, checked against an arithmetic reference model of the rules.
module tb_fp_normalize_pack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [27:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  typedef struct {
    logic [31:0] result;
    logic        ov;
    logic        uf;
    logic        inx;
    int          lat;
    int          acceptEdge;
  } expT;

  expT expQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  cyc = 0;
  bit  randReady = 0;
  bit  holding = 0;
  expT cur;

  fp_normalize_pack dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .in_nan        (in_nan),
    .in_inf        (in_inf),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Randomly throttle the consumer while the random phase runs.
  always @(negedge clk) if (randReady) out_ready = ($urandom_range(0, 3) != 0);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference: value-level normalization, RNE by remainder against one half,
  // then IEEE field assembly.
  function automatic expT refModel(input bit s, input int e, input longint m,
                                   input bit nan, input bit inf);
    expT r;
    int shifts = 0;
    longint sig;
    longint rem;
    r.ov = 0; r.uf = 0; r.inx = 0; r.acceptEdge = 0;
    r.result = 32'h0;
    if (nan) begin r.result = 32'h7FC00000; r.lat = 2; return r; end
    if (inf) begin r.result = {s, 8'hFF, 23'h0}; r.lat = 2; return r; end
    if (e <= -28) begin m = (m != 0) ? 1 : 0; e = 1; shifts++; end
    forever begin
      if (m >= (64'd1 << 27) || e < 1) begin
        m = (m >> 1) | (m & 1); e++; shifts++;
      end else if (m != 0 && m < (64'd1 << 26) && e > 1) begin
        m = m * 2; e--; shifts++;
      end else break;
    end
    r.lat = shifts + 3;
    if (m == 0) begin r.result = {s, 31'h0}; return r; end
    sig = m >> 3;
    rem = m % 8;
    if (rem > 4 || (rem == 4 && (sig % 2) == 1)) sig++;
    r.inx = (rem != 0);
    if (sig == (64'd1 << 24)) begin sig = sig / 2; e++; end
    if (e >= 255) begin
      r.result = {s, 8'hFF, 23'h0}; r.ov = 1; r.inx = 1;
    end else if (sig >= (64'd1 << 23)) begin
      r.result = {s, 8'(e), 23'(sig - (64'd1 << 23))};
    end else begin
`ifdef FP_DENORM_EN
      r.result = {s, 8'h00, 23'(sig)};
      r.uf = (sig != 0) && r.inx;
`else
      r.result = {s, 31'h0};
      r.uf = 1; r.inx = 1;
`endif
    end
    return r;
  endfunction

  task automatic applyStimulus(input bit s, input int e, input logic [27:0] m,
                               input bit nan, input bit inf);
    expT x;
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin reportTimeout("in_ready_wait"); return; end
    x = refModel(s, e, {36'h0, m}, nan, inf);
    x.acceptEdge = cyc + 1;
    expQ.push_back(x);
    in_sign = s; in_exp = e[9:0]; in_mant = m; in_nan = nan; in_inf = inf;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  // Monitor: pop the scoreboard when a new result appears, then watch it hold.
  always @(negedge clk) begin
    if (rst) holding = 0;
    else if (out_valid) begin
      if (!holding) begin
        holding = 1;
        if (expQ.size() == 0) reportTimeout("unexpected_output");
        else begin
          cur = expQ.pop_front();
          checkOutput("result", out_result, cur.result);
          checkOutput("overflow", {31'h0, out_overflow}, {31'h0, cur.ov});
          checkOutput("underflow", {31'h0, out_underflow}, {31'h0, cur.uf});
          checkOutput("inexact", {31'h0, out_inexact}, {31'h0, cur.inx});
          checkOutput("latency", cyc - cur.acceptEdge + 1, cur.lat);
        end
      end else begin
        checkOutput("hold_result", out_result, cur.result);
        checkOutput("hold_flags", {29'h0, out_overflow, out_underflow, out_inexact},
                    {29'h0, cur.ov, cur.uf, cur.inx});
      end
    end else holding = 0;
  end

  initial begin
    expT stallExp;
    int e;
    int k;
    logic [27:0] m;
    int r;
    rst = 1; in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0;
    in_nan = 0; in_inf = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    checkOutput("reset_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("reset_result", out_result, 32'h0);
    checkOutput("reset_flags", {29'h0, out_overflow, out_underflow, out_inexact}, 32'h0);

    applyStimulus(0, 127, 28'd1 << 26, 0, 0);
    applyStimulus(0, 127, 28'd1 << 27, 0, 0);
    applyStimulus(0, 133, 28'd1 << 20, 0, 0);
    applyStimulus(0, 127, (28'd1 << 26) | (28'd1 << 3) | (28'd1 << 2), 0, 0);
    applyStimulus(0, 127, (28'd1 << 26) | (28'd1 << 2), 0, 0);
    applyStimulus(0, 254, (28'd1 << 27) - 28'd1, 0, 0);
    applyStimulus(0, -2, 28'd1 << 26, 0, 0);
    applyStimulus(1, 5, 28'd1 << 26, 1, 0);
    applyStimulus(1, 5, 28'd1 << 26, 0, 1);
    applyStimulus(0, 5, 28'd1 << 26, 1, 1);
    applyStimulus(0, -30, 28'd12345, 0, 0);
    applyStimulus(1, 100, 28'd0, 0, 0);

    // Stalled consumer: result must hold and the input side stay closed.
    for (int i = 0; i < 300 && (!in_ready || expQ.size() != 0); i++) @(negedge clk);
    out_ready = 0;
    stallExp = refModel(1, 130, {36'h0, 28'h5A5A5A5}, 0, 0);
    applyStimulus(1, 130, 28'h5A5A5A5, 0, 0);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    if (!out_valid) reportTimeout("stall_out_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", {31'h0, out_valid}, 32'h1);
      checkOutput("stall_in_ready", {31'h0, in_ready}, 32'h0);
      checkOutput("stall_result", out_result, stallExp.result);
    end
    out_ready = 1;

    // Reset in the middle of a long normalization aborts it.
    for (int i = 0; i < 300 && (!in_ready || expQ.size() != 0); i++) @(negedge clk);
    applyStimulus(0, 133, 28'd1 << 20, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    checkOutput("abort_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("abort_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("abort_result", out_result, 32'h0);
    if (expQ.size() != 0) void'(expQ.pop_back());
    repeat (2) @(negedge clk);

    randReady = 1;
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(1, 28);
      m = 28'($urandom & ((32'd1 << k) - 32'd1));
      if (m == 0) m = 28'd1;
      e = int'($urandom_range(0, 340)) - 40;
      r = $urandom_range(0, 15);
      applyStimulus($urandom_range(0, 1) == 1, e, m, r == 0, r == 1);
    end
    randReady = 0;
    out_ready = 1;

    for (int i = 0; i < 500 && (expQ.size() != 0 || !in_ready); i++) @(negedge clk);
    checkOutput("drain_queue", expQ.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog");
  end

endmodule
